uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART async receiver. It is used when that receiver is built with its FIFO option enabled. It captures each received byte plus its parity-error tag on the receiver's one-cycle write strobe, and presents them in order to the APB register interface. It provides full, empty and almost-full status, an occupancy count, and a sticky overflow flag.

Parameters:
AW, 4, address width; depth DEPTH = 2**AW entries; legal range 1..8.
AFULL_LEVEL, 12, AFULL asserts when COUNT >= AFULL_LEVEL; legal range 1..DEPTH.

Ports:
CLK  input  1  system clock; all logic on rising edge
RESET  input  1  asynchronous, active-high reset
WR_EN  input  1  one-cycle write strobe from the receiver (byte complete)
WR_DATA  input  8  received byte
WR_PERR  input  1  parity-error tag for WR_DATA
RD_EN  input  1  read request from the register interface
RD_DATA  output  8  byte popped by the last accepted read
RD_PERR  output  1  parity tag popped with RD_DATA
RD_VALID  output  1  one-cycle pulse: RD_DATA/RD_PERR updated this cycle
FLUSH  input  1  synchronous clear of the buffer contents
OVF_CLR  input  1  clears OVERFLOW
EMPTY  output  1  COUNT == 0
FULL  output  1  COUNT == DEPTH
AFULL  output  1  COUNT >= AFULL_LEVEL
COUNT  output  AW+1  current occupancy, 0..DEPTH
OVERFLOW  output  1  sticky: a write was dropped

Behaviour:
- Reset (async, RESET=1) sets:
  - pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0, AFULL = 0;
  - OVERFLOW = 0, RD_DATA = 0x00, RD_PERR = 0, RD_VALID = 0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all contents immediately; there is no partial state.
- Storage: DEPTH x 9 bits {WR_PERR, WR_DATA}. Write pointer and read pointer are AW bits each and wrap from DEPTH-1 to 0 naturally. COUNT is tracked separately in AW+1 bits.
- Write acceptance: wr_ok = WR_EN & (~FULL | rd_ok). On wr_ok, the entry is stored at the write pointer and the write pointer increments.
- Read acceptance: rd_ok = RD_EN & ~EMPTY. On rd_ok, the entry at the read pointer is registered onto RD_DATA/RD_PERR and the read pointer increments.
- Read timing: RD_VALID = 1 on the following cycle (read latency 1 clock). RD_DATA/RD_PERR hold their value until the next accepted read.
- RD_EN while EMPTY is ignored: no pointer change, no RD_VALID, no error flag.
- COUNT update:
  - +1 on wr_ok only;
  - -1 on rd_ok only;
  - unchanged when both occur or neither occurs.
- EMPTY, FULL and AFULL are registered and consistent with COUNT in the same cycle.
- Simultaneous read and write:
  - when FULL: both accepted, COUNT stays DEPTH, no overflow;
  - when EMPTY: write accepted, read rejected, COUNT becomes 1.
- Overflow: WR_EN & FULL & ~rd_ok drops the byte. Contents and pointers are unchanged, and OVERFLOW is set the next cycle. OVERFLOW stays set until OVF_CLR or FLUSH. If set and OVF_CLR occur in the same cycle, set wins.
- FLUSH (synchronous):
  - next cycle: pointers = 0, COUNT = 0, EMPTY = 1, OVERFLOW = 0;
  - FLUSH overrides WR_EN and RD_EN in the same cycle: the write is discarded and no RD_VALID is produced;
  - RD_DATA keeps its last value.
- No combinational path exists from any input to any output.

Test Plan:
- Reset then idle: EMPTY=1, FULL=0, COUNT=0, OVERFLOW=0, RD_DATA=0x00. Release reset, wait 5 clocks -> values unchanged.
- Write 0x41 (PERR=0), 0x42 (PERR=1), 0x43, then RD_EN x3 -> RD_VALID pulses one cycle after each RD_EN with 0x41/0, 0x42/1, 0x43/0. COUNT goes 3,2,1,0; EMPTY=1 at end.
- Default params, write 16 bytes 0x00..0x0F:
  - AFULL=1 from COUNT=12; FULL=1 at 16.
  - A 17th write of 0xAA -> OVERFLOW=1, COUNT=16.
  - Draining returns 0x00..0x0F in order; 0xAA never appears.
  - OVF_CLR -> OVERFLOW=0.
- FULL with WR_EN+RD_EN in the same cycle (write 0x55) -> COUNT stays 16, OVERFLOW=0. RD_DATA = oldest entry. After 16 more reads the last byte is 0x55, proving pointer wrap.
- EMPTY with WR_EN(0x99)+RD_EN in the same cycle -> no RD_VALID, COUNT=1. Next read returns 0x99.
- Fill 5 bytes, assert FLUSH together with WR_EN and OVERFLOW set -> next cycle COUNT=0, EMPTY=1, OVERFLOW=0. A subsequent RD_EN produces no RD_VALID. Assert RESET asynchronously mid-burst -> all status outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte buffer storing {parity_err, byte} with full/empty/afull status,
// occupancy count and sticky overflow; registered read port with one-cycle valid pulse.
module uart_rx_fifo #(
  parameter int AW          = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          WR_EN,
  input  logic [7:0]    WR_DATA,
  input  logic          WR_PERR,
  input  logic          RD_EN,
  output logic [7:0]    RD_DATA,
  output logic          RD_PERR,
  output logic          RD_VALID,
  input  logic          FLUSH,
  input  logic          OVF_CLR,
  output logic          EMPTY,
  output logic          FULL,
  output logic          AFULL,
  output logic [AW:0]   COUNT,
  output logic          OVERFLOW
);
  localparam int DEPTH = 1 << AW;
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_empty, r_full, r_afull, r_ovf, r_rd_valid, r_rd_perr;
  logic [7:0]    r_rd_data;
  logic          w_rd_ok, w_wr_ok;
  // a write into a full buffer is still accepted when a read frees a slot in the same cycle
  assign w_rd_ok     = RD_EN & ~r_empty;
  assign w_wr_ok     = WR_EN & (~r_full | w_rd_ok);
  assign w_count_nxt = r_count + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);
  always_ff @(posedge CLK)
    if (w_wr_ok && !FLUSH) r_mem[r_wptr] <= {WR_PERR, WR_DATA};
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rd_perr  <= 1'b0;
    end else if (FLUSH) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        {r_rd_perr, r_rd_data} <= r_mem[r_rptr];
        r_rptr                 <= r_rptr + 1'b1;
      end
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= w_count_nxt == '0;
      r_full  <= w_count_nxt == (AW+1)'(DEPTH);
      r_afull <= w_count_nxt >= (AW+1)'(AFULL_LEVEL);
      r_ovf   <= (WR_EN & r_full & ~w_rd_ok) | (r_ovf & ~OVF_CLR);
    end
  assign RD_DATA  = r_rd_data;
  assign RD_PERR  = r_rd_perr;
  assign RD_VALID = r_rd_valid;
  assign EMPTY    = r_empty;
  assign FULL     = r_full;
  assign AFULL    = r_afull;
  assign COUNT    = r_count;
  assign OVERFLOW = r_ovf;
endmodule
